gated_photon_counter: RTL

GATED_PHOTON_COUNTER -- requirements
Module: gated_photon_counter

---
 rtl/gated_photon_counter_pkg.sv | 19 +
 rtl/sync_edge_detect.sv | 27 ++
 rtl/gated_photon_counter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/gated_photon_counter_pkg.sv
// rtl/gated_photon_counter_pkg.sv - shared state encoding and parameter defaults
package gated_photon_counter_pkg;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_GATE_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // A single channel still needs a one-bit channel index on the result port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchroniser with rising-edge pulse for one photon input
module sync_edge_detect (
  input  logic clk50Mhz,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= sig;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/gated_photon_counter.sv
// rtl/gated_photon_counter.sv - multi-channel gated photon counter with per-channel result drain
module gated_photon_counter
  import gated_photon_counter_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GATE_W = DEF_GATE_W
) (
  input  logic                        clk50Mhz,
  input  logic                        rst,
  input  logic [N_CH-1:0]             sig,
  input  logic                        start,
  input  logic [GATE_W-1:0]           gate_len,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ch_width(N_CH)-1:0]   out_ch,
  output logic [CNT_W-1:0]            out_cnt,
  output logic                        out_sat,
  output logic                        done
);

  localparam int CH_W = ch_width(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t                         state;
  logic [GATE_W-1:0]              gate_rem;
  logic [N_CH-1:0]                pulse;
  logic [N_CH-1:0]                sat_all;
  logic [N_CH-1:0][CNT_W-1:0]     cnt_all;
  logic                           accept_start;
  logic                           counting;

  assign accept_start = (state == IDLE) && start && (gate_len != '0);
  assign counting     = (state == COUNT);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    sync_edge_detect u_sync (
      .clk50Mhz (clk50Mhz),
      .rst      (rst),
      .sig      (sig[i]),
      .pulse    (pulse[i])
    );

    // Saturate instead of wrapping; the flag records that edges were lost.
    always_ff @(posedge clk50Mhz or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (accept_start) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (counting && pulse[i]) begin
        if (&cnt_q) begin
          sat_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign cnt_all[i] = cnt_q;
    assign sat_all[i] = sat_q;
  end

  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gate_rem  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_start) begin
            gate_rem <= gate_len;
            busy     <= 1'b1;
            state    <= COUNT;
          end
        end
        COUNT: begin
          if (gate_rem == GATE_W'(1)) begin
            out_valid <= 1'b1;
            out_ch    <= '0;
            state     <= DRAIN;
          end else begin
            gate_rem <= gate_rem - 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_ch == LAST_CH) begin
              out_valid <= 1'b0;
              out_ch    <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              out_ch <= out_ch + 1'b1;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Counters are frozen during DRAIN, so the beat follows out_ch directly.
  assign out_cnt = out_valid ? cnt_all[out_ch] : '0;
  assign out_sat = out_valid ? sat_all[out_ch] : 1'b0;

endmodule
